// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM state encodings, widths and timing defaults
package dram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_CYC = 3'd1,
        ST_DMA_CYC = 3'd2,
        ST_REF_CYC = 3'd3,
        ST_GAP     = 3'd4
    } dram_state_t;

    localparam int DRAM_ADDR_W               = 28;
    localparam int REF_CNT_W                 = 12;
    localparam int REFRESH_CYCLE_CNT_DEFAULT = 374;
    localparam int DMA_MAX_WAIT_DEFAULT      = 4;

    function automatic logic is_mem_cycle(input dram_state_t s);
        return (s == ST_CPU_CYC) || (s == ST_DMA_CYC) || (s == ST_REF_CYC);
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - free-running refresh interval counter with pending flag
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REFRESH_CYCLE_CNT = REFRESH_CYCLE_CNT_DEFAULT
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    output logic expire,
    output logic pending
);

    logic [REF_CNT_W-1:0] cnt;

    // The count wraps as it reaches REFRESH_CYCLE_CNT, so expiries are exactly that many cycles apart.
    assign expire = (cnt == REF_CNT_W'(REFRESH_CYCLE_CNT - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt <= expire ? '0 : cnt + 1'b1;
            if (clear)
                pending <= 1'b0;
            else if (expire)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/dram_arb.sv
// rtl/dram_arb.sv - DRAM owner arbiter between refresh, CPU and DMA with DMA starvation guard
module dram_arb
    import dram_pkg::*;
#(
    parameter int REFRESH_CYCLE_CNT = REFRESH_CYCLE_CNT_DEFAULT,
    parameter int DMA_MAX_WAIT      = DMA_MAX_WAIT_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   CPU_REQ,
    input  logic [DRAM_ADDR_W-1:0] CPU_ADDR,
    input  logic                   CPU_RnW,
    input  logic [1:0]             CPU_SIZ,
    input  logic                   DMA_REQ,
    input  logic [DRAM_ADDR_W-1:0] DMA_ADDR,
    input  logic                   DMA_RnW,
    input  logic [1:0]             DMA_SIZ,
    output logic                   MEM_REQ,
    output logic                   MEM_REF,
    output logic [DRAM_ADDR_W-1:0] MEM_ADDR,
    output logic                   MEM_RnW,
    output logic [1:0]             MEM_SIZ,
    input  logic                   MEM_DONE,
    output logic                   CPU_ACK,
    output logic                   DMA_ACK,
    output logic                   DMA_GNT
);

    localparam logic [2:0] WAIT_MAX = 3'(DMA_MAX_WAIT);

    dram_state_t state, state_nxt;
    logic [2:0]  dma_wait;
    logic        dma_at_max, dma_starved;
    logic        cpu_grant, dma_grant;
    logic        ref_expire, ref_pending, ref_clear;

    dram_refresh_timer #(
        .REFRESH_CYCLE_CNT(REFRESH_CYCLE_CNT)
    ) u_refresh_timer (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (ref_clear),
        .expire (ref_expire),
        .pending(ref_pending)
    );

    assign dma_at_max  = (dma_wait == WAIT_MAX);
    assign dma_starved = DMA_REQ && dma_at_max;

    always_comb begin
        state_nxt = state;
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        ref_clear = 1'b0;
        MEM_REQ   = is_mem_cycle(state);
        MEM_REF   = (state == ST_REF_CYC);
        DMA_GNT   = (state == ST_DMA_CYC);
        case (state)
            ST_IDLE: begin
                if (ref_pending) begin
                    state_nxt = ST_REF_CYC;
                end else if (dma_starved) begin
                    state_nxt = ST_DMA_CYC;
                    dma_grant = 1'b1;
                end else if (CPU_REQ) begin
                    state_nxt = ST_CPU_CYC;
                    cpu_grant = 1'b1;
                end else if (DMA_REQ) begin
                    state_nxt = ST_DMA_CYC;
                    dma_grant = 1'b1;
                end
            end
            ST_CPU_CYC, ST_DMA_CYC: begin
                if (MEM_DONE)
                    state_nxt = ST_GAP;
            end
            ST_REF_CYC: begin
                // A new expiry landing on this completion must stay queued.
                if (MEM_DONE) begin
                    state_nxt = ST_GAP;
                    ref_clear = !ref_expire;
                end
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= ST_IDLE;
            MEM_ADDR <= '0;
            MEM_RnW  <= 1'b1;
            MEM_SIZ  <= '0;
            CPU_ACK  <= 1'b0;
            DMA_ACK  <= 1'b0;
            dma_wait <= '0;
        end else begin
            state   <= state_nxt;
            CPU_ACK <= (state == ST_CPU_CYC) && MEM_DONE;
            DMA_ACK <= (state == ST_DMA_CYC) && MEM_DONE;
            if (cpu_grant) begin
                MEM_ADDR <= CPU_ADDR;
                MEM_RnW  <= CPU_RnW;
                MEM_SIZ  <= CPU_SIZ;
            end else if (dma_grant) begin
                MEM_ADDR <= DMA_ADDR;
                MEM_RnW  <= DMA_RnW;
                MEM_SIZ  <= DMA_SIZ;
            end
            // Only CPU wins that actually bypass a waiting DMA count toward starvation.
            if (dma_grant)
                dma_wait <= '0;
            else if (cpu_grant && DMA_REQ && !dma_at_max)
                dma_wait <= dma_wait + 3'd1;
        end
    end

endmodule

// File: tb/tb_dram_arb.sv
// tb/tb_dram_arb.sv - randomized and directed bench for dram_arb against a behavioural owner model
module tb_dram_arb;

    localparam int N    = 374;
    localparam int MAXW = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        CPU_REQ = 1'b0;
    logic [27:0] CPU_ADDR = '0;
    logic        CPU_RnW = 1'b1;
    logic [1:0]  CPU_SIZ = '0;
    logic        DMA_REQ = 1'b0;
    logic [27:0] DMA_ADDR = '0;
    logic        DMA_RnW = 1'b1;
    logic [1:0]  DMA_SIZ = '0;
    logic        MEM_DONE = 1'b0;
    logic        MEM_REQ, MEM_REF, MEM_RnW, CPU_ACK, DMA_ACK, DMA_GNT;
    logic [27:0] MEM_ADDR;
    logic [1:0]  MEM_SIZ;

    dram_arb dut (
        .CLK(CLK), .nRST(nRST),
        .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_RnW(CPU_RnW), .CPU_SIZ(CPU_SIZ),
        .DMA_REQ(DMA_REQ), .DMA_ADDR(DMA_ADDR), .DMA_RnW(DMA_RnW), .DMA_SIZ(DMA_SIZ),
        .MEM_REQ(MEM_REQ), .MEM_REF(MEM_REF), .MEM_ADDR(MEM_ADDR), .MEM_RnW(MEM_RnW),
        .MEM_SIZ(MEM_SIZ), .MEM_DONE(MEM_DONE), .CPU_ACK(CPU_ACK), .DMA_ACK(DMA_ACK),
        .DMA_GNT(DMA_GNT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the DRAM after each clock edge.
    typedef enum {O_IDLE, O_CPU, O_DMA, O_REF, O_GAP} owner_t;
    owner_t      m_own = O_IDLE;
    bit          m_pend = 1'b0;
    bit          m_ref_done = 1'b0;
    int          m_edge = 0;
    int          m_wait = 0;
    logic [27:0] m_addr = '0;
    logic        m_rnw = 1'b1;
    logic [1:0]  m_siz = '0;
    bit          m_cack = 1'b0;
    bit          m_dack = 1'b0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_own = O_IDLE; m_pend = 0; m_edge = 0; m_wait = 0;
            m_addr = '0; m_rnw = 1'b1; m_siz = '0; m_cack = 0; m_dack = 0;
        end else begin
            m_cack = 0; m_dack = 0; m_ref_done = 0;
            case (m_own)
                O_IDLE: begin
                    if (m_pend) begin
                        m_own = O_REF;
                    end else if ((DMA_REQ && m_wait >= MAXW) || (DMA_REQ && !CPU_REQ)) begin
                        m_own = O_DMA; m_wait = 0;
                        m_addr = DMA_ADDR; m_rnw = DMA_RnW; m_siz = DMA_SIZ;
                    end else if (CPU_REQ) begin
                        m_own = O_CPU;
                        m_addr = CPU_ADDR; m_rnw = CPU_RnW; m_siz = CPU_SIZ;
                        if (DMA_REQ) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
                    end
                end
                O_CPU: if (MEM_DONE) begin m_cack = 1; m_own = O_GAP; end
                O_DMA: if (MEM_DONE) begin m_dack = 1; m_own = O_GAP; end
                O_REF: if (MEM_DONE) begin m_ref_done = 1; m_own = O_GAP; end
                default: m_own = O_IDLE;
            endcase
            m_edge++;
            if (m_edge % N == 0) m_pend = 1;
            else if (m_ref_done) m_pend = 0;
        end
    end

    // Stimulus knobs and observers
    bit          chk_en = 0;
    int          cpu_rate = 0, dma_rate = 0, spur_rate = 0;
    int          lat_min = 1, lat_max = 5, lat = 0;
    bit          busy = 0, prev_req = 0;
    bit          cpu_kick = 0, dma_kick = 0, spur_kick = 0;
    logic [27:0] k_addr = '0;
    logic        k_rnw = 1'b1;
    logic [1:0]  k_siz = '0;
    int          n_cack = 0, n_dack = 0;
    byte         glog[$];
    logic [27:0] g_addr = '0;
    logic        g_rnw = 1'b0;
    logic [1:0]  g_siz = '0;

    always @(negedge CLK) begin
        if (chk_en) begin
            check("ctl", 64'({MEM_REQ, MEM_REF, DMA_GNT, CPU_ACK, DMA_ACK}),
                  64'({m_own inside {O_CPU, O_DMA, O_REF}, m_own == O_REF, m_own == O_DMA, m_cack, m_dack}));
            check("addr", 64'({MEM_ADDR, MEM_RnW, MEM_SIZ}), 64'({m_addr, m_rnw, m_siz}));
        end
        if (CPU_ACK) n_cack++;
        if (DMA_ACK) n_dack++;
        if (MEM_REQ && !prev_req) begin
            glog.push_back(MEM_REF ? "R" : (DMA_GNT ? "D" : "C"));
            g_addr = MEM_ADDR; g_rnw = MEM_RnW; g_siz = MEM_SIZ;
        end
        prev_req = MEM_REQ;
        if (!nRST) begin
            CPU_REQ = 0; DMA_REQ = 0; MEM_DONE = 0; busy = 0; prev_req = 0;
        end else begin
            MEM_DONE = 0;
            if (MEM_REQ) begin
                if (!busy) begin busy = 1; lat = $urandom_range(lat_max, lat_min); end
                else if (lat == 0) begin MEM_DONE = 1; busy = 0; end
                else lat--;
            end else if (spur_kick || $urandom_range(0, 99) < spur_rate) begin
                MEM_DONE = 1; spur_kick = 0;
            end
            if (CPU_REQ && CPU_ACK) CPU_REQ = 0;
            else if (!CPU_REQ && (cpu_kick || $urandom_range(0, 99) < cpu_rate)) begin
                CPU_REQ = 1;
                CPU_ADDR = cpu_kick ? k_addr : 28'($urandom());
                CPU_RnW  = cpu_kick ? k_rnw : 1'($urandom());
                CPU_SIZ  = cpu_kick ? k_siz : 2'($urandom());
                cpu_kick = 0;
            end
            if (DMA_REQ && DMA_ACK) DMA_REQ = 0;
            else if (!DMA_REQ && (dma_kick || $urandom_range(0, 99) < dma_rate)) begin
                DMA_REQ = 1; DMA_ADDR = 28'($urandom());
                DMA_RnW = 1'($urandom()); DMA_SIZ = 2'($urandom());
                dma_kick = 0;
            end
        end
    end

    task automatic do_reset(input string tag);
        @(posedge CLK);
        #2 nRST = 1'b0;
        chk_en = 1;
        #1 check(tag, 64'({MEM_REQ, MEM_REF, DMA_GNT, CPU_ACK, DMA_ACK, MEM_ADDR, MEM_RnW, MEM_SIZ}),
                 64'({5'b0, 28'd0, 1'b1, 2'd0}));
        repeat (3) @(negedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string tag);
        int b = 2000;
        while (glog.size() < n && b > 0) begin @(posedge CLK); b--; end
        check(tag, 64'(glog.size() >= n), 64'd1);
    endtask

    function automatic int find_d(input int from);
        for (int i = from; i < glog.size(); i++)
            if (glog[i] == "D") return i;
        return -1;
    endfunction

    int n0, c0, d0, i1, i2, b;

    initial begin
        // single CPU write, fixed latency
        do_reset("rst_s1");
        n0 = glog.size(); c0 = n_cack;
        lat_min = 3; lat_max = 3;
        @(posedge CLK);
        k_addr = 28'h0123456; k_rnw = 1'b0; k_siz = 2'd2; cpu_kick = 1;
        b = 200;
        while (n_cack == c0 && b > 0) begin @(posedge CLK); b--; end
        repeat (4) @(posedge CLK);
        check("s1_ack_count", 64'(n_cack - c0), 64'd1);
        check("s1_addr", 64'({g_addr, g_rnw, g_siz}), 64'({28'h0123456, 1'b0, 2'd2}));
        check("s1_kind", 64'(glog.size() > n0 ? glog[n0] : 8'd0), 64'("C"));

        // simultaneous CPU and DMA
        do_reset("rst_s2");
        n0 = glog.size(); lat_min = 1; lat_max = 4;
        @(posedge CLK);
        cpu_kick = 1; dma_kick = 1;
        wait_grants(n0 + 2, "s2_grants");
        if (glog.size() >= n0 + 2)
            check("s2_order", 64'({glog[n0], glog[n0 + 1]}), 64'("CD"));
        repeat (20) @(posedge CLK);

        // CPU hammering while DMA waits
        do_reset("rst_s3");
        n0 = glog.size(); lat_min = 1; lat_max = 3;
        @(posedge CLK);
        cpu_rate = 100; dma_rate = 100;
        wait_grants(n0 + 10, "s3_grants");
        cpu_rate = 0; dma_rate = 0;
        i1 = find_d(n0);
        i2 = (i1 >= 0) ? find_d(i1 + 1) : -1;
        check("s3_dma_first", 64'(i1 - n0), 64'd4);
        check("s3_dma_again", 64'(i2 - i1 - 1), 64'd4);
        repeat (40) @(posedge CLK);

        // refresh expiry during a CPU cycle
        do_reset("rst_s4");
        n0 = glog.size(); lat_min = 8; lat_max = 8;
        b = 1000;
        while (m_edge < N - 6 && b > 0) begin @(negedge CLK); b--; end
        #1 cpu_kick = 1; cpu_rate = 100;
        wait_grants(n0 + 3, "s4_grants");
        cpu_rate = 0;
        if (glog.size() >= n0 + 3)
            check("s4_order", 64'({glog[n0], glog[n0 + 1], glog[n0 + 2]}), 64'("CRC"));
        repeat (40) @(posedge CLK);

        // reset in the middle of a DMA cycle
        do_reset("rst_s5a");
        lat_min = 10; lat_max = 10;
        @(posedge CLK);
        dma_kick = 1;
        b = 100;
        while (!DMA_GNT && b > 0) begin @(negedge CLK); b--; end
        check("s5_gnt", 64'(DMA_GNT), 64'd1);
        d0 = n_dack;
        repeat (2) @(posedge CLK);
        do_reset("s5_rst_mid");
        repeat (20) @(posedge CLK);
        check("s5_no_ack", 64'(n_dack - d0), 64'd0);

        // spurious MEM_DONE while idle
        do_reset("rst_s6");
        n0 = glog.size(); c0 = n_cack; d0 = n_dack;
        repeat (3) @(posedge CLK);
        spur_kick = 1;
        repeat (10) @(posedge CLK);
        check("s6_ack", 64'({n_cack - c0, n_dack - d0}), 64'd0);
        check("s6_grant", 64'(glog.size() - n0), 64'd0);

        // random traffic, several refresh periods
        do_reset("rst_rand");
        n0 = glog.size(); lat_min = 1; lat_max = 5;
        @(posedge CLK);
        cpu_rate = 25; dma_rate = 20; spur_rate = 5;
        repeat (3000) @(posedge CLK);
        cpu_rate = 0; dma_rate = 0; spur_rate = 0;
        repeat (60) @(posedge CLK);
        check("rand_activity", 64'(glog.size() > n0 + 50), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_arb.md
DRAM_ARB -- requirements
Module: dram_arb

Interface
REQ-001 Parameter REFRESH_CYCLE_CNT, default 374: number of CLK cycles between refresh requests (50MHz, 7.8125us row period, with margin).
REQ-002 Parameter DMA_MAX_WAIT, default 4: number of consecutive CPU grants a pending DMA request tolerates before it is forced ahead.
REQ-003 Clocking and reset: one clock, CLK; reset nRST is asynchronous and active-low.
REQ-004 Port list (name, direction, width, meaning):
- CLK  in  1  DRAM clock, 50MHz.
- nRST  in  1  asynchronous active-low reset.
- CPU_REQ  in  1  synchronized CPU access request (AS & RAMSEL); level, held until CPU_ACK, then dropped.
- CPU_ADDR  in  28  CPU address.
- CPU_RnW  in  1  CPU direction.
- CPU_SIZ  in  2  CPU size.
- DMA_REQ  in  1  DMA access request; level, held until DMA_ACK.
- DMA_ADDR  in  28  DMA address.
- DMA_RnW  in  1  DMA direction.
- DMA_SIZ  in  2  DMA size.
- MEM_REQ  out  1  access request to the DRAM sequencer.
- MEM_REF  out  1  refresh request to the DRAM sequencer.
- MEM_ADDR  out  28  muxed address.
- MEM_RnW  out  1  muxed direction.
- MEM_SIZ  out  2  muxed size.
- MEM_DONE  in  1  one-cycle pulse from the sequencer; current access or refresh complete.
- CPU_ACK  out  1  one-cycle completion pulse to the CPU path.
- DMA_ACK  out  1  one-cycle completion pulse to the DMA path.
- DMA_GNT  out  1  high while a DMA cycle owns the DRAM.

Function
REQ-005 The block SHALL implement states IDLE, CPU_CYC, DMA_CYC, REF_CYC and GAP.
REQ-006 In IDLE, the block SHALL select the next owner with priority: refresh pending > DMA starved (wait count reaches DMA_MAX_WAIT) > CPU_REQ > DMA_REQ; one-cycle IDLE-to-cycle latency.
REQ-007 On entry to CPU_CYC or DMA_CYC, the block SHALL register MEM_ADDR, MEM_RnW and MEM_SIZ from the winner and hold them stable until MEM_DONE.
REQ-008 MEM_REQ (and MEM_REF in REF_CYC) SHALL be high throughout the cycle state and low in IDLE and GAP.
REQ-009 On MEM_DONE in CPU_CYC or DMA_CYC, the block SHALL pulse the matching ACK for exactly one cycle, deassert MEM_REQ and go to GAP.
REQ-010 On MEM_DONE in REF_CYC, the block SHALL clear refresh pending and go to GAP.
REQ-011 GAP SHALL last exactly one cycle and then return to IDLE; this lets the requester drop REQ before re-arbitration.
REQ-012 A MEM_DONE arriving in IDLE or GAP SHALL be ignored.
REQ-013 The 12-bit refresh counter SHALL count every cycle; on reaching REFRESH_CYCLE_CNT it SHALL set refresh pending and wrap to 0.
REQ-014 A refresh expiry that occurs while refresh is already pending SHALL not be queued twice.
REQ-015 A refresh expiry that coincides with MEM_DONE in REF_CYC SHALL leave refresh pending set.
REQ-016 The 3-bit DMA wait counter SHALL increment on each CPU grant while DMA_REQ is high, saturate at DMA_MAX_WAIT, and clear on a DMA grant.
REQ-017 DMA_GNT SHALL equal (state == DMA_CYC).
REQ-018 Simultaneous CPU_REQ and DMA_REQ with no starvation SHALL grant the CPU.

Reset
REQ-019 While nRST is low, the block SHALL force:
- state to IDLE;
- MEM_REQ, MEM_REF, CPU_ACK, DMA_ACK and DMA_GNT to 0;
- MEM_ADDR to 0, MEM_RnW to 1, MEM_SIZ to 0;
- refresh counter, refresh pending and DMA wait counter to 0.
REQ-020 Reset asserted mid-cycle SHALL abandon the cycle with no ACK issued.

Structure
REQ-021 State encodings and the default REFRESH_CYCLE_CNT SHALL live in a shared DRAM package that is also used by the sequencer.
REQ-022 The refresh counter SHALL be a sub-module named dram_refresh_timer, with outputs expire and pending and input clear.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- CPU_REQ=1, ADDR=0x0123456, RnW=0; MEM_DONE 4 cycles later -> MEM_ADDR=0x0123456, MEM_RnW=0 held, one CPU_ACK pulse, then GAP and IDLE.
- CPU_REQ and DMA_REQ rise in the same cycle -> CPU granted first; DMA granted after the CPU GAP.
- CPU re-requests continuously while DMA_REQ is held -> DMA granted no later than after the 4th CPU grant; wait counter then 0.
- Refresh counter reaches 374 while a CPU cycle is active -> REF_CYC follows that GAP ahead of a pending CPU_REQ; MEM_REF high until MEM_DONE.
- nRST pulsed low during DMA_CYC -> all outputs at reset values, no DMA_ACK, state IDLE.
- Spurious MEM_DONE in IDLE -> no ACK and no state change.
